// File: rtl/page_map_ctrl_pkg.sv
// Shared definitions for the page map controller and the page map itself.
// Holds the page map opcode encodings, the controller status codes, the
// controller FSM state type and the operand range check helper.
package page_map_ctrl_pkg;

    // Page map opcodes
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_DEL = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    // Sticky completion status codes
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_BAD_OP  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } ctrl_state_t;

    // A page window is illegal when empty or when it runs past page 255.
    // The sum is formed at 9 bits so from=255,size=1 (sum 256) stays legal.
    function automatic logic range_bad(input logic [7:0] from, input logic [7:0] size);
        logic [8:0] sum;
        sum = {1'b0, from} + {1'b0, size};
        return (size == 8'd0) || (sum > 9'd256);
    endfunction

endpackage

// File: rtl/page_map_ctrl_rr_arb2.sv
// Two-way round-robin arbiter (module rr_arb2).
// Ports:
//   req[1:0]  in   request vector (already qualified by the caller)
//   last      in   index of the requester served most recently
//   grant     out  one-hot grant, zero when nothing requests
//   last_upd  out  new last-served index to store when the grant is used
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       last_upd
);

    always_comb begin
        grant = req;
        // Contention: favour whichever requester was not served last.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    assign last_upd = grant[1];

endmodule

// File: rtl/page_map_ctrl.sv
// Page map command controller.
// Arbitrates two command requesters, range-checks the accepted command,
// issues it to the page map for one cycle, ignores pm_valid for a settle
// window, then waits (bounded) for pm_valid before signalling completion.
// Ports:
//   clk200, a8_rst              clock, asynchronous active-high reset
//   rq0_* / rq1_*               requester valid/ready handshake + op/from/size
//   pm_op, pm_from, pm_size     command to the page map (op non-zero one cycle)
//   pm_valid                    page map state valid
//   busy, done, done_src, err   controller status
module page_map_ctrl
    import page_map_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 2
) (
    input  logic       clk200,
    input  logic       a8_rst,
    input  logic       rq0_valid,
    output logic       rq0_ready,
    input  logic [1:0] rq0_op,
    input  logic [7:0] rq0_from,
    input  logic [7:0] rq0_size,
    input  logic       rq1_valid,
    output logic       rq1_ready,
    input  logic [1:0] rq1_op,
    input  logic [7:0] rq1_from,
    input  logic [7:0] rq1_size,
    output logic [1:0] pm_op,
    output logic [7:0] pm_from,
    output logic [7:0] pm_size,
    input  logic       pm_valid,
    output logic       busy,
    output logic       done,
    output logic       done_src,
    output logic [1:0] err
);

    // One counter serves both the settle window and the wait timeout,
    // sized so the larger of the two limits fits without wrapping.
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    ctrl_state_t state_reg, state_next;
    logic [1:0]  op_reg, op_next;
    logic [7:0]  from_reg, from_next;
    logic [7:0]  size_reg, size_next;
    logic        src_reg, src_next;
    logic [1:0]  err_reg, err_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [7:0]  pm_from_reg, pm_from_next;
    logic [7:0]  pm_size_reg, pm_size_next;
    logic        last_reg, last_next;

    logic [1:0]  arb_req;
    logic [1:0]  grant;
    logic        last_upd;

    // Requests are only presented in IDLE, and never while reset is held,
    // so ready cannot be asserted during reset.
    assign arb_req = {rq1_valid, rq0_valid} & {2{(state_reg == ST_IDLE) && !a8_rst}};

    rr_arb2 u_arb (
        .req      (arb_req),
        .last     (last_reg),
        .grant    (grant),
        .last_upd (last_upd)
    );

    always_ff @(posedge clk200 or posedge a8_rst) begin
        if (a8_rst) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_NOP;
            from_reg    <= 8'd0;
            size_reg    <= 8'd0;
            src_reg     <= 1'b0;
            err_reg     <= ERR_OK;
            cnt_reg     <= '0;
            pm_from_reg <= 8'd0;
            pm_size_reg <= 8'd0;
            last_reg    <= 1'b1;   // "last served = 1" gives requester 0 priority
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            from_reg    <= from_next;
            size_reg    <= size_next;
            src_reg     <= src_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            pm_from_reg <= pm_from_next;
            pm_size_reg <= pm_size_next;
            last_reg    <= last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        from_next    = from_reg;
        size_next    = size_reg;
        src_next     = src_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        pm_from_next = pm_from_reg;
        pm_size_next = pm_size_reg;
        last_next    = last_reg;
        pm_op        = OP_NOP;
        done         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant[0]) begin
                    op_next   = rq0_op;
                    from_next = rq0_from;
                    size_next = rq0_size;
                    src_next  = 1'b0;
                end else if (grant[1]) begin
                    op_next   = rq1_op;
                    from_next = rq1_from;
                    size_next = rq1_size;
                    src_next  = 1'b1;
                end
                if (grant != 2'b00) begin
                    err_next   = ERR_OK;
                    last_next  = last_upd;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                cnt_next = '0;
                if (op_reg == OP_NOP) begin
                    err_next   = ERR_BAD_OP;
                    state_next = ST_DONE;
                end else if (op_reg == OP_CLR) begin
                    pm_from_next = 8'd0;
                    pm_size_next = 8'd0;
                    state_next   = ST_ISSUE;
                end else if (range_bad(from_reg, size_reg)) begin
                    err_next   = ERR_RANGE;
                    state_next = ST_DONE;
                end else begin
                    pm_from_next = from_reg;
                    pm_size_next = size_reg;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pm_op      = op_reg;
                cnt_next   = '0;
                state_next = (SETTLE == 0) ? ST_WAIT : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_reg == CW'(SETTLE - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_WAIT: begin
                if (pm_valid) begin
                    state_next = ST_DONE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_next   = ERR_TIMEOUT;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rq0_ready = grant[0];
    assign rq1_ready = grant[1];
    assign busy      = (state_reg != ST_IDLE);
    assign done_src  = src_reg;
    assign err       = err_reg;
    assign pm_from   = pm_from_reg;
    assign pm_size   = pm_size_reg;

endmodule
